stream_width_downsizer: RTL and testbench

// - Splits each wide valid/ready word into Ratio = InWidth/OutWidth narrow beats, LSB slice first.
// - Flags the final beat of each word with out_last_o.
// - Sits in the destination clock domain, directly downstream of the isochronous spill register.
//   It consumes that register's dst_valid/dst_ready/dst_data stream and feeds the narrow link.
// - One-entry holding buffer plus beat counter.
// - No bubble between words when the downstream never stalls.

---
 rtl/stream_width_downsizer_if.sv | 30 +++
 rtl/stream_width_downsizer.sv | 82 ++++++++
 tb/tb_stream_width_downsizer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/stream_width_downsizer_if.sv
// Stream bundle for stream_width_downsizer.
//   in_valid_i / in_ready_o / in_data_i / in_beats_i : wide word stream (upstream side)
//   out_valid_o / out_ready_i / out_data_o / out_last_o : narrow beat stream (downstream side)
// Modports:
//   slave  - the downsizer's view (consumes words, produces beats)
//   master - the environment's view (produces words, consumes beats)
interface stream_width_downsizer_if #(
  parameter int unsigned InWidth  = 64,
  parameter int unsigned OutWidth = 16,
  parameter int unsigned BeatW    = $clog2(InWidth / OutWidth) + 1
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [InWidth-1:0]  in_data_i;
  logic [BeatW-1:0]    in_beats_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [OutWidth-1:0] out_data_o;
  logic                out_last_o;

  modport slave (
    input  in_valid_i, in_data_i, in_beats_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o
  );

  modport master (
    output in_valid_i, in_data_i, in_beats_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/stream_width_downsizer.sv
// Splits each wide valid/ready word into up to Ratio = InWidth/OutWidth narrow
// beats, LSB slice first, flagging the final beat with out_last_o. A word may
// carry fewer valid beats (in_beats_i); its upper slices are never emitted.
// One-entry holding buffer plus beat counter; a new word loads in the same
// cycle the previous word's last beat leaves, so there is no bubble.
// Ports:
//   clk_i  - clock
//   rst_ni - synchronous, active-low reset
//   bus    - stream_width_downsizer_if.slave (word in, beat out)
module stream_width_downsizer #(
  parameter int unsigned InWidth  = 64,
  parameter int unsigned OutWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  stream_width_downsizer_if.slave bus
);
  localparam int unsigned Ratio = InWidth / OutWidth;
  localparam int unsigned BeatW = $clog2(Ratio) + 1;
  localparam int unsigned CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;

  if ((InWidth % OutWidth) != 0 || Ratio < 2) begin : g_bad_params
    $fatal(1, "stream_width_downsizer: InWidth must be a multiple of OutWidth with Ratio >= 2");
  end

  logic                           full_q;
  logic [Ratio-1:0][OutWidth-1:0] buf_q;
  logic [BeatW-1:0]               beats_q;
  logic [CntW-1:0]                cnt_q;

  logic in_hs, out_hs, last_beat;

  // 0 or anything above Ratio means a full word.
  function automatic logic [BeatW-1:0] clamp_beats(input logic [BeatW-1:0] b);
    if (b == '0 || b > BeatW'(Ratio)) return BeatW'(Ratio);
    return b;
  endfunction

  assign last_beat       = full_q && (BeatW'(cnt_q) == beats_q - BeatW'(1));
  assign bus.out_valid_o = full_q;
  assign bus.out_data_o  = buf_q[cnt_q];
  assign bus.out_last_o  = last_beat;
  // Combinational from out_ready_i: accept the next word while the last beat leaves.
  assign bus.in_ready_o  = !full_q || (full_q && bus.out_ready_i && last_beat);

  assign in_hs  = bus.in_valid_i && bus.in_ready_o;
  assign out_hs = full_q && bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      buf_q   <= '0;
      beats_q <= BeatW'(Ratio);
      cnt_q   <= '0;
    end else if (in_hs) begin
      // Covers both the idle load and the back-to-back load on a last beat.
      full_q  <= 1'b1;
      buf_q   <= bus.in_data_i;
      beats_q <= clamp_beats(bus.in_beats_i);
      cnt_q   <= '0;
    end else if (out_hs) begin
      if (last_beat) begin
        full_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  a_in_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.in_valid_i && !bus.in_ready_o) |=>
      (bus.in_valid_i && $stable(bus.in_data_i) && $stable(bus.in_beats_i)))
    else $error("input changed while waiting for in_ready_o");

  a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.out_valid_o && !bus.out_ready_i) |=>
      ($stable(bus.out_data_o) && $stable(bus.out_last_o)))
    else $error("output changed under stall");
`endif
endmodule

// File: tb/tb_stream_width_downsizer.sv
module tb_stream_width_downsizer;
  localparam int unsigned InW  = 64;
  localparam int unsigned OutW = 16;
  localparam int unsigned R    = InW / OutW;

  typedef struct {
    logic [OutW-1:0] data;
    bit              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  stream_width_downsizer_if #(.InWidth(InW), .OutWidth(OutW)) bus ();

  stream_width_downsizer #(.InWidth(InW), .OutWidth(OutW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: every accepted word becomes its list of LSB-first slices.
  task automatic push_word(input logic [InW-1:0] data, input int beats);
    int n;
    beat_t b;
    n = (beats == 0 || beats > int'(R)) ? int'(R) : beats;
    for (int i = 0; i < n; i++) begin
      b.data = data[i*OutW +: OutW];
      b.last = (i == n - 1);
      q.push_back(b);
    end
  endtask

  // Inputs are set at the negedge; outputs are compared 1ns later, then one clock.
  task automatic tick(output bit acc);
    bit exp_ready;
    acc = 1'b0;
    #1;
    if (!rst_n) begin
      @(posedge clk);
      q.delete();
      @(negedge clk);
      return;
    end
    check("out_valid", 64'(bus.out_valid_o), 64'(q.size() != 0));
    exp_ready = (q.size() == 0) || (q.size() == 1 && bus.out_ready_i === 1'b1);
    check("in_ready", 64'(bus.in_ready_o), 64'(exp_ready));
    if (q.size() != 0) begin
      check("out_data", 64'(bus.out_data_o), 64'(q[0].data));
      check("out_last", 64'(bus.out_last_o), 64'(q[0].last));
      if (bus.out_ready_i) void'(q.pop_front());
    end
    if (bus.in_valid_i && bus.in_ready_o) begin
      acc = 1'b1;
      push_word(bus.in_data_i, int'(bus.in_beats_i));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [InW-1:0] data, input int beats, input bit rnd_ready);
    bit acc;
    acc = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = data;
    bus.in_beats_i = 3'(beats);
    for (int k = 0; k < 100 && !acc; k++) begin
      if (rnd_ready) bus.out_ready_i = 1'($urandom_range(0, 1));
      tick(acc);
    end
    if (!acc) check("accept_timeout", 64'(0), 64'(1));
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain(input bit rnd_ready);
    bit acc;
    for (int k = 0; k < 300 && q.size() != 0; k++) begin
      bus.out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(acc);
    end
    check("drain_empty", 64'(q.size()), 64'(0));
    bus.out_ready_i = 1'b1;
    tick(acc);
  endtask

  initial begin
    bit acc;
    rst_n          = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.in_beats_i = '0;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    tick(acc);
    tick(acc);
    rst_n = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
    check("rst_out_last",  64'(bus.out_last_o),  64'(0));
    check("rst_in_ready",  64'(bus.in_ready_o),  64'(1));
    check("rst_out_data",  64'(bus.out_data_o),  64'h0000);
    tick(acc);

    // Full word, no stalls
    bus.out_ready_i = 1'b1;
    send_word(64'h4444_3333_2222_1111, 4, 1'b0);
    #1;
    check("first_beat", 64'(bus.out_data_o), 64'h1111);
    drain(1'b0);

    // Stall three cycles on the second beat
    send_word(64'h4444_3333_2222_1111, 4, 1'b0);
    tick(acc);
    bus.out_ready_i = 1'b0;
    tick(acc); tick(acc); tick(acc);
    #1;
    check("stall_hold", 64'(bus.out_data_o), 64'h2222);
    bus.out_ready_i = 1'b1;
    drain(1'b0);

    // Short word: upper slices never appear
    send_word(64'hDEAD_BEEF_CAFE_F00D, 2, 1'b0);
    drain(1'b0);

    // Back-to-back: clamped 0 then single beat, valid held high
    send_word(64'h8888_7777_6666_5555, 0, 1'b0);
    send_word(64'h0000_0000_0000_9999, 1, 1'b0);
    drain(1'b0);

    // Reset in the middle of a word
    send_word(64'hAAAA_BBBB_CCCC_DDDD, 4, 1'b0);
    tick(acc); tick(acc);
    rst_n = 1'b0;
    tick(acc);
    rst_n = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid_o), 64'(0));
    check("midrst_in_ready",  64'(bus.in_ready_o),  64'(1));
    send_word(64'h1234_5678_9ABC_DEF0, 4, 1'b0);
    #1;
    check("midrst_slice0", 64'(bus.out_data_o), 64'hDEF0);
    drain(1'b0);

    // Random words, beat counts and backpressure
    for (int w = 0; w < 40; w++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        bus.out_ready_i = 1'($urandom_range(0, 1));
        tick(acc);
      end
      send_word({$urandom, $urandom}, int'($urandom_range(0, 7)), 1'b1);
    end
    drain(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
